// File: rtl/prog_count_div_pkg.sv
// Shared constants for the programmable counter/divider.
package prog_count_div_pkg;

  // Step mode encodings as seen on the mode input.
  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // Bounce direction state.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage : prog_count_div_pkg

// File: rtl/prog_count_div_tick_gen.sv
// Programmable-ratio step strobe generator with a 50% square-wave output.
module tick_gen #(
  parameter int unsigned DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             step_c,
  output logic             clk_out
);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap_c;

  // >= so that shrinking the ratio below the current count wraps at once.
  assign wrap_c = (div_cnt >= div_ratio);
  assign step_c = !rst && !clear && en && wrap_c;

  // Period counter and square wave; clear drops the partial period but keeps clk_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      clk_out <= 1'b0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (en) begin
      if (wrap_c) begin
        div_cnt <= '0;
        clk_out <= ~clk_out;
      end else begin
        div_cnt <= DIV_W'(div_cnt + 1'b1);
      end
    end
  end

endmodule : tick_gen

// File: rtl/prog_count_div.sv
// Counter/divider: programmable tick, multi-mode step counter, terminal-count flag.
module prog_count_div
  import prog_count_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             clk_out,
  output logic             tc,
  output logic             dir
);

  logic             step_c;
  dir_t             dir_state;
  dir_t             dir_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] bounce_top_c;
  logic [WIDTH-1:0] bounce_bot_c;

  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clear     (load),
    .div_ratio (div_ratio),
    .step_c    (step_c),
    .clk_out   (clk_out)
  );

  // Turn-around values; a zero ceiling pins the bounce at 0.
  assign bounce_top_c = (max_val == '0) ? '0 : WIDTH'(max_val - 1'b1);
  assign bounce_bot_c = (max_val == '0) ? '0 : WIDTH'(1);

  // Count, direction and terminal-count registers; load outranks stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_state <= DIR_UP;
      count     <= '0;
      tick      <= 1'b0;
      tc        <= 1'b0;
    end else if (load) begin
      dir_state <= DIR_UP;
      count     <= load_val;
      tick      <= 1'b0;
      tc        <= 1'b0;
    end else begin
      dir_state <= dir_nxt;
      count     <= count_nxt;
      tick      <= step_c;
      tc        <= tc_nxt;
    end
  end

  // Next count/direction per mode; direction resets whenever not bouncing.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    dir_nxt   = (mode == MODE_BOUNCE) ? dir_state : DIR_UP;
    if (step_c) begin
      unique case (mode)
        MODE_UP: begin
          if (count >= max_val) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = WIDTH'(count + 1'b1);
          end
        end
        MODE_DOWN: begin
          if (count == '0) begin
            count_nxt = max_val;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = WIDTH'(count - 1'b1);
          end
        end
        MODE_BOUNCE: begin
          if (dir_state == DIR_UP) begin
            if (count >= max_val) begin
              dir_nxt   = DIR_DOWN;
              tc_nxt    = 1'b1;
              count_nxt = bounce_top_c;
            end else begin
              count_nxt = WIDTH'(count + 1'b1);
            end
          end else begin
            if (count == '0) begin
              dir_nxt   = DIR_UP;
              tc_nxt    = 1'b1;
              count_nxt = bounce_bot_c;
            end else begin
              count_nxt = WIDTH'(count - 1'b1);
            end
          end
        end
        default: begin
          count_nxt = count;
        end
      endcase
    end
  end

  assign dir = (dir_state == DIR_DOWN);

endmodule : prog_count_div

// File: tb/tb_prog_count_div.sv
// Scoreboard bench for prog_count_div: reference model plus directed sequences.
module tb_prog_count_div;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_ratio;
  logic [1:0]       mode;
  logic [WIDTH-1:0] max_val;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             clk_out;
  logic             tc;
  logic             dir;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             clk_out;
    logic             tc;
    logic             dir;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [WIDTH-1:0] m_count = '0;
  logic [DIV_W-1:0] m_div   = '0;
  logic             m_clk   = 1'b0;
  logic             m_dir   = 1'b0;
  logic             m_tick  = 1'b0;
  logic             m_tc    = 1'b0;

  prog_count_div #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_ratio (div_ratio),
    .mode      (mode),
    .max_val   (max_val),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .tick      (tick),
    .clk_out   (clk_out),
    .tc        (tc),
    .dir       (dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_edge();
    logic step;
    logic ndir;
    step = 1'b0;
    if (rst) begin
      m_count = '0; m_div = '0; m_clk = 1'b0; m_dir = 1'b0; m_tick = 1'b0; m_tc = 1'b0;
    end else if (load) begin
      m_count = load_val; m_div = '0; m_dir = 1'b0; m_tick = 1'b0; m_tc = 1'b0;
    end else begin
      ndir = (mode == 2'b10) ? m_dir : 1'b0;
      m_tc = 1'b0;
      if (en) begin
        if (m_div >= div_ratio) begin
          m_div = '0;
          step  = 1'b1;
        end else begin
          m_div = m_div + 1;
        end
      end
      m_tick = step;
      if (step) begin
        m_clk = ~m_clk;
        case (mode)
          2'b00: if (m_count >= max_val) begin m_count = '0; m_tc = 1'b1; end
                 else m_count = m_count + 1;
          2'b01: if (m_count == 0) begin m_count = max_val; m_tc = 1'b1; end
                 else m_count = m_count - 1;
          2'b10: begin
            if (!m_dir) begin
              if (m_count >= max_val) begin
                ndir = 1'b1; m_tc = 1'b1;
                m_count = (max_val == 0) ? 0 : max_val - 1;
              end else m_count = m_count + 1;
            end else begin
              if (m_count == 0) begin
                ndir = 1'b0; m_tc = 1'b1;
                m_count = (max_val == 0) ? 0 : 1;
              end else m_count = m_count - 1;
            end
          end
          default: ;
        endcase
      end
      m_dir = ndir;
    end
  endtask

  // One clock: push expectation, take the edge, pop and compare.
  task automatic cycle();
    exp_t e;
    model_edge();
    e.count = m_count; e.tick = m_tick; e.clk_out = m_clk; e.tc = m_tc; e.dir = m_dir;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_count",   int'(count),   int'(e.count));
    chk("sb_tick",    int'(tick),    int'(e.tick));
    chk("sb_clk_out", int'(clk_out), int'(e.clk_out));
    chk("sb_tc",      int'(tc),      int'(e.tc));
    chk("sb_dir",     int'(dir),     int'(e.dir));
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int up_seq[6];
    int bn_seq[7];
    int bn_dir[7];
    int dn_seq[3];
    up_seq = '{1, 2, 3, 4, 5, 0};
    bn_seq = '{1, 2, 3, 2, 1, 0, 1};
    bn_dir = '{0, 0, 0, 1, 1, 1, 0};
    dn_seq = '{1, 0, 9};

    rst = 1'b1; en = 1'b0; div_ratio = '0; mode = 2'b00;
    max_val = '0; load = 1'b0; load_val = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_clk_out", int'(clk_out), 0);

    // Divider: ratio 3, ticks every 4 cycles
    en = 1'b1; div_ratio = 8'd3; mode = 2'b00; max_val = 4'd15;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      chk("div_tick", int'(tick), (k % 4 == 0) ? 1 : 0);
      chk("div_count", int'(count), k / 4);
      chk("div_clk_out", int'(clk_out), (k / 4) % 2);
    end

    // Up wrap at max_val 5
    do_reset();
    en = 1'b1; div_ratio = 8'd0; mode = 2'b00; max_val = 4'd5;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("up_count", int'(count), up_seq[k]);
      chk("up_tc", int'(tc), (k == 5) ? 1 : 0);
    end

    // Bounce 0..3
    do_reset();
    en = 1'b1; div_ratio = 8'd0; mode = 2'b10; max_val = 4'd3;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("bn_count", int'(count), bn_seq[k]);
      chk("bn_dir", int'(dir), bn_dir[k]);
      chk("bn_tc", int'(tc), (k == 3 || k == 6) ? 1 : 0);
    end

    // Down with load, then load and reset together
    do_reset();
    mode = 2'b01; max_val = 4'd9; en = 1'b0; load = 1'b1; load_val = 4'd2;
    cycle();
    chk("ld_count", int'(count), 2);
    chk("ld_tick", int'(tick), 0);
    load = 1'b0; en = 1'b1; div_ratio = 8'd0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("dn_count", int'(count), dn_seq[k]);
      chk("dn_tc", int'(tc), (k == 2) ? 1 : 0);
    end
    load = 1'b1; rst = 1'b1; load_val = 4'd7;
    cycle();
    chk("ldrst_count", int'(count), 0);
    rst = 1'b0; load = 1'b0;

    // Enable gating mid-period
    do_reset();
    en = 1'b1; div_ratio = 8'd4; mode = 2'b00; max_val = 4'd15;
    cycle(); cycle();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("gate_tick", int'(tick), 0);
      chk("gate_count", int'(count), 0);
      chk("gate_clk_out", int'(clk_out), 0);
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("resume_tick", int'(tick), (k == 3) ? 1 : 0);
    end
    chk("resume_count", int'(count), 1);
    chk("resume_clk_out", int'(clk_out), 1);

    // Ratio shrink below div_cnt, then hold
    do_reset();
    en = 1'b1; div_ratio = 8'd10; mode = 2'b00; max_val = 4'd15;
    for (int k = 0; k < 7; k++) cycle();
    chk("pre_shrink_tick", int'(tick), 0);
    div_ratio = 8'd2;
    cycle();
    chk("shrink_tick", int'(tick), 1);
    chk("shrink_count", int'(count), 1);
    mode = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      chk("hold_tick", int'(tick), (k % 3 == 0) ? 1 : 0);
      chk("hold_count", int'(count), 1);
      chk("hold_tc", int'(tc), 0);
      chk("hold_clk_out", int'(clk_out), ((k / 3) % 2 == 0) ? 1 : 0);
    end

    // Randomised traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 24) == 0);
      load_val = WIDTH'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) max_val = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) div_ratio = DIV_W'($urandom_range(0, 3));
      cycle();
    end
    rst = 1'b0; load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prog_count_div

// File: doc/prog_count_div.md
# prog_count_div

Parametrised counter/divider combining a programmable-ratio clock-enable generator with a multi-mode step counter (up, down, bounce, hold), synchronous load and terminal-count flag. It sits directly on the board clock and produces a one-cycle `tick` strobe, a 50 % `clk_out` square wave and a stepped `count` value. Downstream display and timing logic use these outputs; they never use derived clocks. It generalises the fixed 3-bit counter and fixed-ratio clock divider to arbitrary widths, runtime ratio and direction modes.

## Interface
- `WIDTH`, 8: counter width in bits.
- `DIV_W`, 27: divider width in bits. 27 bits reaches about 1 Hz from 100 MHz.

- `clk`  in  1: system clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset. This is the only reset; one clock domain.
- `en`  in  1: divider/counter enable.
- `div_ratio`  in  DIV_W: tick period minus one.
- `mode`  in  2: 00 up, 01 down, 10 bounce, 11 hold.
- `max_val`  in  WIDTH: terminal (upper) count value.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  WIDTH: value written on `load`.
- `count`  out  WIDTH: current count.
- `tick`  out  1: one-cycle step strobe.
- `clk_out`  out  1: square wave, toggles on every tick.
- `tc`  out  1: one-cycle terminal-count pulse.
- `dir`  out  1: bounce direction, 0 up, 1 down.

## Operation
- Priority on each edge, highest first: `rst`, then `load`, then the `en` step.
- **Reset:** `count`=0, `tick`=0, `clk_out`=0, `tc`=0, `dir`=0, internal `div_cnt`=0.
- **Load:**
  - Sets `count`=`load_val`, `div_cnt`=0, `tick`=0, `tc`=0, `dir`=0.
  - `clk_out` holds. `en` is ignored.
- **Divider, when `en`=1:**
  - If `div_cnt` >= `div_ratio`: `div_cnt`←0 and a step occurs.
  - Otherwise: `div_cnt`+1.
  - The comparison is >=, so lowering `div_ratio` below `div_cnt` wraps on the next edge.
- **Divider, when `en`=0:** `div_cnt`, `count`, `dir` and `clk_out` hold; `tick`=0, `tc`=0.
- **Step (same edge):** `tick`←1 and `clk_out`←~`clk_out`. `tick`/`tc` are 0 on all non-step edges. Step behaviour by mode:
  - **Up:** if `count` >= `max_val`, then `count`←0 and `tc`←1; else `count`+1.
  - **Down:** if `count`==0, then `count`←`max_val` and `tc`←1; else `count`−1.
  - **Bounce, state UP (`dir`=0):** if `count` >= `max_val`, then `dir`←1, `tc`←1, `count`←`max_val`−1 (0 if `max_val`=0); else `count`+1.
  - **Bounce, state DOWN (`dir`=1):** if `count`==0, then `dir`←0, `tc`←1, `count`←1 (0 if `max_val`=0); else `count`−1.
  - **Hold:** `count` holds, `tc`=0. `tick` and `clk_out` still run.
- `dir` is forced to 0 on any edge where `mode`≠10. Entering bounce therefore always starts in UP.
- Arithmetic is modulo 2^WIDTH, with no wrap other than the rules above. `max_val`=0 in up or bounce mode keeps `count` at 0 with `tc` on every step.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- From reset release with `en`=1: first `tick` is high in cycle `div_ratio`+1 (edge index `div_ratio`+1), then every `div_ratio`+1 cycles.
- `div_ratio`=0 gives `tick` every cycle, with `clk_out` period 2 cycles.
- `count` and `tc` change on the same edge that raises `tick`. `tc` is never high without `tick`.
- `clk_out` period is 2·(`div_ratio`+1) cycles; duty is exactly 50 %.
- Changes to `mode` and `max_val` take effect at the next step. `div_ratio` is compared every cycle.
- `load` and `rst` mid-period discard the partial period. The next tick comes `div_ratio`+1 cycles after release.

## Structure
- Package `prog_count_div_pkg` holds:
  - Mode constants: `MODE_UP`, `MODE_DOWN`, `MODE_BOUNCE`, `MODE_HOLD`.
  - Direction state constants: `DIR_UP`, `DIR_DOWN`.
- Sub-module `tick_gen` owns:
  - Inputs: `clk`, `rst`, `en`, `clear`, `div_ratio`.
  - Outputs: the combinational step strobe and registered `clk_out`.
  - `clear` is driven by `load`.
- The top level holds the count register, the bounce direction FSM and the `tc`/`tick` registers.

## Test plan
- **Divider:** WIDTH=4, `div_ratio`=3, `mode`=up, `max_val`=15, `en`=1 from reset. Required: `tick` at cycles 4, 8, 12; `count` reads 1, 2, 3 after them; `clk_out` period 8.
- **Up wrap:** `div_ratio`=0, `max_val`=5. Required: `count` 0,1,2,3,4,5,0; `tc` high only on the 5→0 edge.
- **Bounce:** `div_ratio`=0, `max_val`=3, `mode`=10. Required: `count` 0,1,2,3,2,1,0,1; `tc` on 3→2 and 0→1; `dir` 1 during 2,1,0.
- **Down with load:** `mode`=down, `max_val`=9, `load`=1 with `load_val`=2, then `en`=1, `div_ratio`=0. Required: 2,1,0,9 with `tc` on 0→9. Asserting `load` and `rst` together yields `count`=0.
- **Enable gating:** `en` low for 5 cycles mid-period with `div_ratio`=4. Required: `div_cnt`, `count` and `clk_out` frozen; `tick`=0; period resumes where it stopped.
- **Ratio shrink and hold:** `div_ratio` changed 10→2 while `div_cnt`=7. Required: tick on the next edge. Then `mode`=hold: `tick`/`clk_out` continue, `count` constant, `tc`=0.
